// File: rtl/arith_execute_unit_pkg.sv
// Shared encodings for the arithmetic decoder and execute stage.
package arith_execute_unit_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;

    localparam logic [1:0] B_SEL_A = 2'b00;
    localparam logic [1:0] B_SEL_B = 2'b01;
    localparam logic [1:0] B_SEL_C = 2'b10;
    localparam logic [1:0] B_SEL_D = 2'b11;

    localparam logic [3:0] DEST_A = 4'b0001;
    localparam logic [3:0] DEST_B = 4'b0010;
    localparam logic [3:0] DEST_C = 4'b0100;
    localparam logic [3:0] DEST_D = 4'b1000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ITER   = 2'b01,
        FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/arith_execute_unit_mul_div_iter.sv
// Iterative 8x8 shift-add multiplier / restoring divider, one bit per step.
module mul_div_iter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       op,      // 0 multiply, 1 divide
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       step,
    output logic       last,
    output logic [7:0] lo,
    output logic [7:0] hi
);

    // MUL: p = {acc[8:0], multiplier[7:0]}; DIV: p = {rem[8:0], dividend/quotient[7:0]}
    logic [16:0] p, p_next;
    logic [7:0]  d;
    logic [2:0]  cnt;
    logic        op_q;
    logic [8:0]  sum;
    logic [16:0] sh;

    always_comb begin
        sum = 9'(p[15:8]) + (p[0] ? {1'b0, d} : 9'd0);
        sh  = {p[15:0], 1'b0};
        if (!op_q)
            p_next = {1'b0, sum, p[7:1]};
        else if (sh[16:8] >= {1'b0, d})
            p_next = {sh[16:8] - {1'b0, d}, sh[7:1], 1'b1};
        else
            p_next = sh;
    end

    // lo/hi present the post-step value so the caller can capture on the last step
    assign lo   = p_next[7:0];
    assign hi   = p_next[15:8];
    assign last = (cnt == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p    <= '0;
            d    <= '0;
            cnt  <= '0;
            op_q <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            op_q <= op;
            p    <= {9'd0, op ? a : b};
            d    <= op ? b : a;
        end else if (step) begin
            p   <= p_next;
            cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/arith_execute_unit.sv
// Execute stage: operand muxes, single-cycle add/sub, iterative mul/div, flags.
module arith_execute_unit
    import arith_execute_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] alu_sel,
    input  logic       acc_sel,
    input  logic [1:0] alu_b_sel,
    input  logic [3:0] destination_reg_flag,
    input  logic [7:0] reg_a,
    input  logic [7:0] reg_b,
    input  logic [7:0] reg_c,
    input  logic [7:0] reg_d,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [7:0] result_hi,
    output logic [3:0] wr_en,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       flag_divzero
);

    state_t     state, state_next;
    logic [7:0] op_a, op_b;
    logic [8:0] add_sum, sub_diff;
    logic [2:0] sel_q;
    logic [3:0] wr_q;
    logic       accept, is_long, it_last;
    logic [7:0] it_lo, it_hi;

    always_comb begin
        op_a = acc_sel ? result : reg_a;
        case (alu_b_sel)
            B_SEL_A: op_b = reg_a;
            B_SEL_B: op_b = reg_b;
            B_SEL_C: op_b = reg_c;
            default: op_b = reg_d;
        endcase
    end

    assign add_sum  = {1'b0, op_a} + {1'b0, op_b};
    assign sub_diff = {1'b0, op_a} - {1'b0, op_b};
    assign accept   = (state == IDLE) && start;
    assign is_long  = (alu_sel == ALU_MUL) || ((alu_sel == ALU_DIV) && (op_b != 8'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = is_long ? ITER : FINISH;
            ITER:    if (it_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    mul_div_iter u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && is_long),
        .op    (alu_sel == ALU_DIV),
        .a     (op_a),
        .b     (op_b),
        .step  (state == ITER),
        .last  (it_last),
        .lo    (it_lo),
        .hi    (it_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result       <= '0;
            result_hi    <= '0;
            flag_zero    <= 1'b0;
            flag_carry   <= 1'b0;
            flag_divzero <= 1'b0;
            sel_q        <= '0;
            wr_q         <= '0;
        end else if (accept) begin
            sel_q <= alu_sel;
            wr_q  <= destination_reg_flag;
            case (alu_sel)
                ALU_ADD: begin
                    result       <= add_sum[7:0];
                    result_hi    <= '0;
                    flag_zero    <= (add_sum[7:0] == 8'd0);
                    flag_carry   <= add_sum[8];
                    flag_divzero <= 1'b0;
                end
                ALU_SUB: begin
                    result       <= sub_diff[7:0];
                    result_hi    <= '0;
                    flag_zero    <= (sub_diff[7:0] == 8'd0);
                    flag_carry   <= sub_diff[8];
                    flag_divzero <= 1'b0;
                end
                ALU_MUL: ;
                ALU_DIV: begin
                    if (op_b == 8'd0) begin
                        result       <= 8'hFF;
                        result_hi    <= op_a;
                        flag_zero    <= 1'b0;
                        flag_carry   <= 1'b0;
                        flag_divzero <= 1'b1;
                        wr_q         <= '0;
                    end
                end
                default: wr_q <= '0;  // reserved: completes without touching state
            endcase
        end else if (state == ITER && it_last) begin
            result       <= it_lo;
            result_hi    <= it_hi;
            flag_zero    <= (it_lo == 8'd0);
            flag_carry   <= (sel_q == ALU_MUL) && (it_hi != 8'd0);
            flag_divzero <= 1'b0;
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == FINISH);
    assign wr_en = done ? wr_q : 4'd0;

endmodule

// File: tb/tb_arith_execute_unit.sv
// Self-checking bench: directed test-plan cases plus randomized ops against a latency/arith model.
module tb_arith_execute_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] alu_sel = '0;
    logic       acc_sel = 1'b0;
    logic [1:0] alu_b_sel = '0;
    logic [3:0] destination_reg_flag = '0;
    logic [7:0] reg_a = '0, reg_b = '0, reg_c = '0, reg_d = '0;
    logic       busy, done, flag_zero, flag_carry, flag_divzero;
    logic [7:0] result, result_hi;
    logic [3:0] wr_en;

    int checks = 0;
    int errors = 0;

    arith_execute_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_sel(alu_sel), .acc_sel(acc_sel),
        .alu_b_sel(alu_b_sel), .destination_reg_flag(destination_reg_flag),
        .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi), .wr_en(wr_en),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_divzero(flag_divzero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining-cycle count plus the outcome computed at issue.
    int         rem = 0;
    logic [7:0] m_res = 0, m_hi = 0;
    logic       m_z = 0, m_c = 0, m_dz = 0, m_done = 0;
    logic [3:0] m_wr = 0;
    int         p_res, p_hi, p_wr;
    bit         p_z, p_c, p_dz, p_upd;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            rem = 0; m_res = 0; m_hi = 0; m_z = 0; m_c = 0; m_dz = 0; m_done = 0; m_wr = 0;
        end else begin
            if (rem > 0) rem--;
            else if (start) begin
                int a, b, lat;
                a = acc_sel ? int'(m_res) : int'(reg_a);
                case (alu_b_sel)
                    2'd0: b = reg_a;
                    2'd1: b = reg_b;
                    2'd2: b = reg_c;
                    default: b = reg_d;
                endcase
                lat = 1; p_upd = 1; p_wr = destination_reg_flag; p_hi = 0; p_c = 0; p_dz = 0;
                case (alu_sel)
                    3'd0: begin p_res = (a + b) % 256; p_c = (a + b) > 255; end
                    3'd1: begin p_res = (a - b + 256) % 256; p_c = a < b; end
                    3'd2: begin p_res = (a * b) % 256; p_hi = (a * b) / 256; p_c = p_hi != 0; lat = 9; end
                    3'd3: begin
                        if (b == 0) begin p_res = 255; p_hi = a; p_dz = 1; p_wr = 0; end
                        else begin p_res = a / b; p_hi = a % b; lat = 9; end
                    end
                    default: begin p_upd = 0; p_wr = 0; p_res = 0; end
                endcase
                p_z = (p_res == 0);
                rem = lat;
            end
            m_done = (rem == 1);
            m_wr = m_done ? 4'(p_wr) : 4'd0;
            if (m_done && p_upd) begin
                m_res = 8'(p_res); m_hi = 8'(p_hi); m_z = p_z; m_c = p_c; m_dz = p_dz;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy", 16'(busy), 16'(rem > 0));
        chk("done", 16'(done), 16'(m_done));
        chk("wr_en", 16'(wr_en), 16'(m_wr));
        chk("result", 16'(result), 16'(m_res));
        chk("result_hi", 16'(result_hi), 16'(m_hi));
        chk("flags", 16'({flag_zero, flag_carry, flag_divzero}), 16'({m_z, m_c, m_dz}));
    end

    // Drive one issue at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input logic [2:0] sel, input logic acc, input logic [1:0] bsel,
                         input logic [3:0] dest, input logic [7:0] a, b, c, d);
        alu_sel = sel; acc_sel = acc; alu_b_sel = bsel; destination_reg_flag = dest;
        reg_a = a; reg_b = b; reg_c = c; reg_d = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done; optionally toggles start and scrambles inputs while busy.
    task automatic wait_done(input bit noisy, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin
            if (noisy) begin
                start = 1'($urandom); alu_sel = 3'($urandom);
                reg_a = 8'($urandom); reg_b = 8'($urandom); reg_c = 8'($urandom); reg_d = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        end
    endtask

    initial begin
        int cyc;
        repeat (2) @(negedge clk);
        chk("reset_result", 16'(result), 16'h0);
        chk("reset_busy", 16'({busy, done, wr_en}), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'b000, 0, 2'b01, 4'b0001, 8'hF0, 8'h20, 8'h00, 8'h00);
        chk("add_done", 16'(done), 16'h1);
        chk("add_result", 16'(result), 16'h10);
        chk("add_flags_zc", 16'({flag_zero, flag_carry}), 16'b01);
        chk("add_wr", 16'(wr_en), 16'h1);
        @(negedge clk);

        issue(3'b010, 0, 2'b10, 4'b0100, 8'h10, 8'h00, 8'h10, 8'h00);
        wait_done(0, cyc);
        chk("mul_lat", 16'(cyc), 16'd9);
        chk("mul_result", 16'({result_hi, result}), 16'h0100);
        chk("mul_flags_zc", 16'({flag_zero, flag_carry}), 16'b11);
        @(negedge clk);

        issue(3'b011, 0, 2'b11, 4'b0010, 8'h64, 8'h00, 8'h00, 8'h07);
        wait_done(0, cyc);
        chk("div_lat", 16'(cyc), 16'd9);
        chk("div_result", 16'({result_hi, result}), 16'h020E);
        @(negedge clk);
        issue(3'b011, 0, 2'b01, 4'b0010, 8'h64, 8'h00, 8'h00, 8'h07);
        chk("div0_done", 16'(done), 16'h1);
        chk("div0_result", 16'({result_hi, result}), 16'h64FF);
        chk("div0_flag", 16'(flag_divzero), 16'h1);
        chk("div0_wr", 16'(wr_en), 16'h0);
        @(negedge clk);

        issue(3'b001, 0, 2'b01, 4'b0001, 8'h05, 8'h07, 8'h00, 8'h00);
        chk("sub_result", 16'(result), 16'hFE);
        chk("sub_borrow", 16'(flag_carry), 16'h1);
        @(negedge clk);
        alu_sel = 3'b010; alu_b_sel = 2'b01; reg_a = 8'h03; reg_b = 8'h05; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin
            alu_sel = 3'b000; reg_a = 8'($urandom); reg_b = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("held_lat", 16'(cyc), 16'd9);
        chk("held_result", 16'({result_hi, result}), 16'h000F);
        @(negedge clk);

        issue(3'b010, 0, 2'b10, 4'b0100, 8'h10, 8'h00, 8'h10, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_outs", 16'({busy, done, wr_en, flag_zero, flag_carry, flag_divzero}), 16'h0);
        chk("rst_result", 16'({result_hi, result}), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(3'b000, 0, 2'b00, 4'b0001, 8'h01, 8'h00, 8'h00, 8'h00);
        chk("post_rst_add", 16'(result), 16'h02);
        @(negedge clk);

        issue(3'b000, 0, 2'b01, 4'b0001, 8'h10, 8'h20, 8'h00, 8'h00);
        chk("fwd_first", 16'(result), 16'h30);
        @(negedge clk);
        issue(3'b000, 1, 2'b01, 4'b0001, 8'hAA, 8'h05, 8'h00, 8'h00);
        chk("fwd_second", 16'(result), 16'h35);
        @(negedge clk);
        issue(3'b101, 0, 2'b01, 4'b0001, 8'h11, 8'h22, 8'h00, 8'h00);
        chk("rsv_done", 16'({done, wr_en}), 16'h10);
        chk("rsv_held", 16'(result), 16'h35);
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] r [4];
            logic [1:0] bs;
            for (int k = 0; k < 4; k++) r[k] = 8'($urandom);
            bs = 2'($urandom);
            if ($urandom_range(3) == 0) r[bs] = 8'h00;
            issue(3'($urandom), 1'($urandom), bs, 4'(1 << $urandom_range(3)), r[0], r[1], r[2], r[3]);
            wait_done(1, cyc);
            repeat ($urandom_range(2)) @(negedge clk);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
